// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A 1-bit full-subtractor cell feeds a borrow flip-flop; a small IDLE/RUN/DONE
// controller provides a start/done handshake toward a controlling FSM.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shA_q;
    logic [WIDTH-1:0] shB_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;

    logic             diffBit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] result_d;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        diffBit_d = shA_q[0] ^ shB_q[0] ^ borrow_q;
        borrow_d  = (~shA_q[0] & shB_q[0]) | (~(shA_q[0] ^ shB_q[0]) & borrow_q);
        result_d  = {diffBit_d, result_q[WIDTH-1:1]};
    end

    // Controller, shift registers, borrow flip-flop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shA_q    <= '0;
            shB_q    <= '0;
            result_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shA_q    <= a;
                        shB_q    <= b;
                        borrow_q <= bin;
                        result_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    shA_q    <= {1'b0, shA_q[WIDTH-1:1]};
                    shB_q    <= {1'b0, shB_q[WIDTH-1:1]};
                    result_q <= result_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q  <= result_d;
                        bout_q  <= borrow_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Built around a 1-bit full-subtractor cell plus a borrow flip-flop.
- The inverse arithmetic companion to the team's full-adder datapath.
- Used where area matters more than latency, e.g. ALU decrement/compare paths; start/done handshake toward a controlling FSM.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled high in IDLE or DONE loads operands
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result valid
diff  output  WIDTH  difference, valid from done until next accepted start
bout  output  1  final borrow-out (1 = a < b + bin unsigned)

Behaviour:
- Reset (rst_n low, async, immediate): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift regs, borrow FF and bit counter=0. Reset mid-RUN aborts the operation; no done pulse; outputs 0 after release.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> load sh_a=a, sh_b=b, borrow=bin, cnt=0; go RUN. start=0 -> stay.
- RUN (busy=1): each edge, using LSBs x=sh_a[0], y=sh_b[0], c=borrow:
  - d = x ^ y ^ c
  - borrow <= (~x & y) | (~(x ^ y) & c)
  - result reg shifts right, d enters MSB; sh_a, sh_b shift right; cnt++.
  - After the edge processing cnt=WIDTH-1 -> DONE.
  - start ignored while in RUN; a/b/bin changes have no effect.
- DONE: done=1 for exactly this cycle; diff=result register, bout=borrow.
  - start=1 at this edge -> reload and go RUN (back-to-back; done drops).
  - Otherwise -> IDLE.
- diff/bout are registered, updated only on entry to DONE, held through IDLE; unchanged during the next RUN until its DONE.
- Latency: start accepted at edge k -> done high in cycle after edge k+WIDTH; throughput one op per WIDTH+1 cycles.
- Arithmetic: unsigned modulo 2^WIDTH; diff = (a - b - bin) mod 2^WIDTH; bout = 1 iff a < b + bin as integers.
  - Signed interpretation is left to the consumer; no overflow flag.
- busy and done never high simultaneously; busy=0 in IDLE and DONE.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start pulse -> busy 8 cycles, done pulse at edge k+8 cycle; diff=63 (0x3F), bout=0.
- a=37, b=100, bin=0 -> diff=0xC1 (193), bout=1; a=0, b=0, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Start held high continuously with new operands each DONE -> back-to-back ops every 9 cycles, each diff correct; no IDLE cycle between ops.
- Second start with different a/b pulsed during RUN -> ignored; first result unchanged, single done pulse.
- rst_n low at cycle 4 of RUN -> busy/done/diff/bout=0 immediately (async); after release, no done until a new start; new op a=5, b=3 -> diff=2, bout=0.
- Random 1000 operand sets vs reference model (a - b - bin): diff and bout match; diff held stable in IDLE between ops.
